pixel_word_packer: RTL and testbench
====================================

// Module: pixel_word_packer
// PURPOSE
//  Downstream of the Mandelbrot top-level pixel stream. Consumes one 24-bit RGB pixel per handshake
//  (r/g/b, first, last_x, last_y, valid/ready) and packs 4 pixels (12 bytes) into 3 32-bit words for
//  the video DMA stream. Emits sof on the frame's first word and eol on each line's last word.
//  Partial words at line end are zero-padded.
// PARAMETERS
//  COLOUR_WIDTH  8   bits per colour channel; packing below requires 8
//  WORD_WIDTH    32  output word width; only 32 supported
// PORTS
//  clk        in   1   system clock, rising edge
//  reset      in   1   asynchronous, active-low; clears all state
//  r,g,b      in   8   pixel colour channels
//  first      in   1   pixel is first of frame
//  last_x     in   1   pixel is last of its line
//  last_y     in   1   pixel is on the last line
//  valid      in   1   upstream pixel valid
//  ready      out  1   packer accepts pixel this cycle
//  out_data   out  32  packed word
//  out_valid  out  1   out_data valid
//  out_ready  in   1   downstream accepts word
//  out_sof    out  1   word contains first pixel of frame
//  out_eol    out  1   last word of a line
//  out_eof    out  1   last word of the frame (eol on a last_y line)
// BEHAVIOUR
//  - Reset (reset=0, async): out_valid=0, out_data=0, out_sof/eol/eof=0, ready=0, held=0, state=RUN.
//  - Byte order: pixel bytes r,g,b in order; word filled LSB-first (byte0 = bits[7:0]).
//  - held: 0..3 leftover bytes from earlier pixels. Accept = valid & ready.
//  - ready = (state==RUN) & (!out_valid | out_ready); 0 while reset is low.
//  - RUN, accept, total = held+3:
//    - total>=4 & !last_x: load out_data from held bytes then new bytes; held = total-4.
//    - total==3 & !last_x: no word; held = 3.
//    - last_x, total 3 or 4: one word, zero-padded if needed; eol=1; held = 0.
//    - last_x, total 5 or 6: full word (eol=0); remaining 1..2 bytes kept; go to FLUSH.
//  - FLUSH: ready=0. When out register frees, load remainder zero-padded with eol=1.
//    Then held=0, state=RUN.
//  - Latency: the word completed by an accepted pixel is visible on out_valid on the next clock edge.
//  - Output register: out_data and out_* flags hold stable while out_valid & !out_ready.
//    A word loads when out_valid=0 or out_ready=1. Load and drain in the same cycle is allowed.
//  - sof: set on the word containing the first byte of a pixel with first=1.
//  - eof: set with eol when the line's last pixel had last_y=1.
//  - first=1 with held!=0 (protocol error): discard held bytes; packing restarts from byte0.
//    Sticky frame_err set, cleared by reset (not a port; visible for verification hierarchically).
//  - Pattern at steady state: held cycles 0->3->2->1->0; words emitted on pixels 2,3,4 of each group.
// CONFIGURATION
//  PACKER_BGR_ORDER_EN defined: per-pixel byte order b,g,r (byte0 = b), for BGR displays.
//  Undefined: r,g,b order as above. No other behaviour changes.
// TESTING
//  1 Line of 4 px (11,22,33),(44,55,66),(77,88,99),(AA,BB,CC), first on px0, last_x on px3,
//    out_ready=1 -> 3 words: 0x44332211 sof, 0x88776655, 0xCCBBAA99 eol.
//  2 Single px (01,02,03), first+last_x+last_y -> one word 0x00030201 with sof, eol, eof; held=0.
//  3 Line of 3 px (01..09) -> 0x04030201, 0x08070605, then FLUSH 0x00000009 eol.
//    ready=0 during the FLUSH cycle.
//  4 Backpressure: out_ready=0 for 5 cycles mid-line -> out_data/flags stable, ready=0, no pixel lost.
//    Sequence identical to test 1 after release.
//  5 Assert reset low mid-line with held=2 -> all outputs 0 immediately.
//    Next frame packs from byte0 with sof.
//  6 PACKER_BGR_ORDER_EN defined, test 2 stimulus -> word 0x00010203.

Source files
------------

// File: rtl/pixel_word_packer.sv
// Packs a 24-bit pixel stream into 32-bit words, 4 pixels per 3 words, zero-padding at line end.
// Optional macro PACKER_BGR_ORDER_EN switches per-pixel byte order to b,g,r.
module pixel_word_packer #(
  parameter int COLOUR_WIDTH = 8,
  parameter int WORD_WIDTH   = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [COLOUR_WIDTH-1:0] r,
  input  logic [COLOUR_WIDTH-1:0] g,
  input  logic [COLOUR_WIDTH-1:0] b,
  input  logic                    first,
  input  logic                    last_x,
  input  logic                    last_y,
  input  logic                    valid,
  output logic                    ready,
  output logic [WORD_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    out_sof,
  output logic                    out_eol,
  output logic                    out_eof
);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t      state;
  logic [1:0]  held;
  logic [23:0] held_bytes;
  logic        sof_pending;
  logic        flush_eof;
  logic        frame_err;

  logic        out_free;
  logic        accept;
  logic [23:0] pixel;
  logic [1:0]  eff_held;
  logic [23:0] eff_bytes;
  logic [47:0] combined;
  logic [2:0]  total;

  assign out_free = !out_valid || out_ready;
  assign ready    = reset && (state == RUN) && out_free;
  assign accept   = valid && ready;

`ifdef PACKER_BGR_ORDER_EN
  assign pixel = {r, g, b};
`else
  assign pixel = {b, g, r};
`endif

  // A first-of-frame pixel discards any leftover bytes, so packing restarts at byte0.
  assign eff_held  = first ? 2'd0  : held;
  assign eff_bytes = first ? 24'd0 : held_bytes;
  assign combined  = ({24'd0, pixel} << {eff_held, 3'b000}) | {24'd0, eff_bytes};
  assign total     = {1'b0, eff_held} + 3'd3;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      held        <= 2'd0;
      held_bytes  <= 24'd0;
      sof_pending <= 1'b0;
      flush_eof   <= 1'b0;
      frame_err   <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_sof     <= 1'b0;
      out_eol     <= 1'b0;
      out_eof     <= 1'b0;
    end else begin
      if (out_valid && out_ready)
        out_valid <= 1'b0;
      case (state)
        RUN: begin
          if (accept) begin
            frame_err <= frame_err | (first && (held != 2'd0));
            if (last_x || (total >= 3'd4)) begin
              out_data    <= combined[31:0];
              out_valid   <= 1'b1;
              out_sof     <= first | sof_pending;
              sof_pending <= 1'b0;
              held_bytes  <= {8'd0, combined[47:32]};
              if (last_x && (total > 3'd4)) begin
                out_eol   <= 1'b0;
                out_eof   <= 1'b0;
                held      <= eff_held - 2'd1;
                flush_eof <= last_y;
                state     <= FLUSH;
              end else if (last_x) begin
                out_eol <= 1'b1;
                out_eof <= last_y;
                held    <= 2'd0;
              end else begin
                out_eol <= 1'b0;
                out_eof <= 1'b0;
                held    <= eff_held - 2'd1;
              end
            end else begin
              held        <= 2'd3;
              held_bytes  <= pixel;
              sof_pending <= sof_pending | first;
            end
          end
        end
        FLUSH: begin
          // The 1..2 byte remainder of a line goes out as its own eol word.
          if (out_free) begin
            out_data   <= {8'd0, held_bytes};
            out_valid  <= 1'b1;
            out_sof    <= 1'b0;
            out_eol    <= 1'b1;
            out_eof    <= flush_eof;
            held       <= 2'd0;
            held_bytes <= 24'd0;
            state      <= RUN;
          end
        end
        default: state <= RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_word_packer.sv
// Self-checking bench for pixel_word_packer: directed cases plus random frames against a byte-queue model.
module tb_pixel_word_packer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  r = 8'd0, g = 8'd0, b = 8'd0;
  logic        first = 1'b0, last_x = 1'b0, last_y = 1'b0, valid = 1'b0;
  logic        ready;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        out_sof, out_eol, out_eof;

  int total_checks = 0;
  int bad_checks = 0;
  logic rand_bp = 1'b0;

  logic [34:0] obs_q[$];
  logic [34:0] exp_q[$];
  logic [23:0] line_px[$];

  pixel_word_packer dut (
    .clk(clk), .reset(reset), .r(r), .g(g), .b(b),
    .first(first), .last_x(last_x), .last_y(last_y), .valid(valid), .ready(ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof)
  );

  always #5 clk = ~clk;

  // Record every word transferred downstream as {sof,eol,eof,data}.
  always @(negedge clk)
    if (reset && out_valid && out_ready)
      obs_q.push_back({out_sof, out_eol, out_eof, out_data});

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_checks++;
    assert (obs === exp) else begin
      bad_checks++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [23:0] px, input logic f, input logic lx, input logic ly);
    logic done;
    logic taken;
    r = px[23:16]; g = px[15:8]; b = px[7:0];
    first = f; last_x = lx; last_y = ly; valid = 1'b1;
    done = 1'b0;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      taken = ready;
      @(posedge clk);
      #1;
      if (taken) done = 1'b1;
      if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
    end
    valid = 1'b0; first = 1'b0; last_x = 1'b0; last_y = 1'b0;
    check_output("accept", {63'd0, done}, 64'd1);
  endtask

  // Reference: a line is a flat byte list cut into 4-byte words, LSB first, last word zero-padded.
  task automatic model_line(input logic frame_first, input logic last_line);
    logic [7:0]  bytes_q[$];
    logic [31:0] word;
    int nw;
    foreach (line_px[i]) begin
`ifdef PACKER_BGR_ORDER_EN
      bytes_q.push_back(line_px[i][7:0]);
      bytes_q.push_back(line_px[i][15:8]);
      bytes_q.push_back(line_px[i][23:16]);
`else
      bytes_q.push_back(line_px[i][23:16]);
      bytes_q.push_back(line_px[i][15:8]);
      bytes_q.push_back(line_px[i][7:0]);
`endif
    end
    nw = (bytes_q.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      word = 32'd0;
      for (int k = 0; k < 4; k++)
        if (w * 4 + k < bytes_q.size()) word[k*8 +: 8] = bytes_q[w*4 + k];
      exp_q.push_back({frame_first && (w == 0), w == nw - 1, (w == nw - 1) && last_line, word});
    end
  endtask

  task automatic send_line(input logic frame_first, input logic last_line);
    for (int i = 0; i < line_px.size(); i++)
      apply_stimulus(line_px[i], frame_first && (i == 0), i == line_px.size() - 1, last_line);
    model_line(frame_first, last_line);
  endtask

  task automatic compare_words(input string tag);
    out_ready = 1'b1;
    for (int c = 0; c < 100 && obs_q.size() < exp_q.size(); c++) begin
      @(posedge clk);
      #1;
    end
    repeat (3) @(posedge clk);
    #1;
    check_output({tag, "_count"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check_output($sformatf("%s_w%0d", tag, i), 64'(obs_q[i]), 64'(exp_q[i]));
    check_output({tag, "_idle"}, {63'd0, out_valid}, 64'd0);
  endtask

  task automatic clear_queues();
    obs_q.delete();
    exp_q.delete();
    line_px.delete();
  endtask

  initial begin
    logic [34:0] snap;
    int nlines;
    int npx;

    #1 reset = 1'b0;
    #1;
    check_output("rst_ready", {63'd0, ready}, 64'd0);
    check_output("rst_valid", {63'd0, out_valid}, 64'd0);
    check_output("rst_data", {32'd0, out_data}, 64'd0);
    check_output("rst_flags", {61'd0, out_sof, out_eol, out_eof}, 64'd0);
    check_output("rst_held", {62'd0, dut.held}, 64'd0);
    #10 reset = 1'b1;
    @(posedge clk);
    #1;
    check_output("post_rst_ready", {63'd0, ready}, 64'd1);

    $display("[TB] line of 4 pixels");
    line_px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    send_line(1'b1, 1'b0);
    compare_words("line4");
`ifndef PACKER_BGR_ORDER_EN
    check_output("line4_spec_w0", 64'(obs_q[0]), {29'd0, 3'b100, 32'h44332211});
    check_output("line4_spec_w2", 64'(obs_q[2]), {29'd0, 3'b010, 32'hCCBBAA99});
`endif
    clear_queues();

    $display("[TB] single pixel frame");
    line_px = '{24'h010203};
    send_line(1'b1, 1'b1);
    check_output("single_held", {62'd0, dut.held}, 64'd0);
    compare_words("single");
`ifdef PACKER_BGR_ORDER_EN
    check_output("single_spec", 64'(obs_q[0]), {29'd0, 3'b111, 32'h00010203});
`else
    check_output("single_spec", 64'(obs_q[0]), {29'd0, 3'b111, 32'h00030201});
`endif
    clear_queues();

    $display("[TB] line of 3 pixels with flush");
    line_px = '{24'h010203, 24'h040506, 24'h070809};
    apply_stimulus(line_px[0], 1'b1, 1'b0, 1'b0);
    apply_stimulus(line_px[1], 1'b0, 1'b0, 1'b0);
    apply_stimulus(line_px[2], 1'b0, 1'b1, 1'b0);
    check_output("flush_ready", {63'd0, ready}, 64'd0);
    @(posedge clk);
    #1;
    check_output("flush_done_ready", {63'd0, ready}, 64'd1);
    model_line(1'b1, 1'b0);
    compare_words("line3");
`ifndef PACKER_BGR_ORDER_EN
    check_output("line3_spec_flush", 64'(obs_q[2]), {29'd0, 3'b010, 32'h00000009});
`endif
    clear_queues();

    $display("[TB] backpressure mid-line");
    line_px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    apply_stimulus(line_px[0], 1'b1, 1'b0, 1'b0);
    apply_stimulus(line_px[1], 1'b0, 1'b0, 1'b0);
    out_ready = 1'b0;
    snap = {out_sof, out_eol, out_eof, out_data};
    r = 8'h77; g = 8'h88; b = 8'h99; valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      check_output($sformatf("bp_hold%0d", c), 64'({out_valid, out_sof, out_eol, out_eof, out_data}), 64'({1'b1, snap}));
      check_output($sformatf("bp_ready%0d", c), {63'd0, ready}, 64'd0);
    end
    check_output("bp_held", {62'd0, dut.held}, 64'd2);
    valid = 1'b0;
    out_ready = 1'b1;
    apply_stimulus(line_px[2], 1'b0, 1'b0, 1'b0);
    apply_stimulus(line_px[3], 1'b0, 1'b1, 1'b0);
    model_line(1'b1, 1'b0);
    compare_words("bp");
    clear_queues();

    $display("[TB] first pixel with leftover bytes");
    apply_stimulus(24'h5A5A5A, 1'b0, 1'b0, 1'b0);
    line_px = '{24'h112233, 24'h445566, 24'h778899, 24'hAABBCC};
    send_line(1'b1, 1'b1);
    check_output("frame_err_set", {63'd0, dut.frame_err}, 64'd1);
    compare_words("proto");
    clear_queues();

    $display("[TB] reset mid-line");
    apply_stimulus(24'hC0C1C2, 1'b1, 1'b0, 1'b0);
    apply_stimulus(24'hC3C4C5, 1'b0, 1'b0, 1'b0);
    check_output("mid_held", {62'd0, dut.held}, 64'd2);
    #1 reset = 1'b0;
    #1;
    check_output("mid_rst_out", 64'({ready, out_valid, out_sof, out_eol, out_eof, out_data}), 64'd0);
    check_output("mid_rst_held", {62'd0, dut.held}, 64'd0);
    check_output("mid_rst_err", {63'd0, dut.frame_err}, 64'd0);
    clear_queues();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    line_px = '{24'h010203};
    send_line(1'b1, 1'b1);
    compare_words("after_rst");
    clear_queues();

    $display("[TB] random frames");
    for (int f = 0; f < 8; f++) begin
      rand_bp = 1'b1;
      nlines = $urandom_range(1, 3);
      for (int l = 0; l < nlines; l++) begin
        npx = $urandom_range(1, 9);
        for (int p = 0; p < npx; p++) line_px.push_back(24'($urandom));
        send_line(l == 0, l == nlines - 1);
        line_px.delete();
      end
      rand_bp = 1'b0;
      compare_words($sformatf("rand%0d", f));
      clear_queues();
    end

    $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
    $finish;
  end

endmodule
